// File: rtl/cpu_pkg.sv
// Shared encodings for the EX-stage multiply/divide engine.
package cpu_pkg;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  localparam int MD_ITERATIONS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_sign_adjust.sv
// Magnitude extraction for incoming operands and sign correction of the
// unsigned accumulator into signed product / quotient / remainder.
module muldiv_sign_adjust
  import cpu_pkg::*;
#(
  parameter int WIDTH = MD_ITERATIONS
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_op,
  input  logic               i_dz,
  input  logic               i_sign_a,
  input  logic               i_sign_b,
  input  logic [2*WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0]   o_mag_a,
  output logic [WIDTH-1:0]   o_mag_b,
  output logic [WIDTH-1:0]   o_lo,
  output logic [WIDTH-1:0]   o_hi
);

  logic               w_neg;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [2*WIDTH-1:0] w_prod;

  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign o_mag_a = i_a[WIDTH-1] ? -i_a : i_a;
  assign o_mag_b = i_b[WIDTH-1] ? -i_b : i_b;

  assign w_neg  = i_sign_a ^ i_sign_b;
  assign w_q    = i_acc[WIDTH-1:0];
  assign w_r    = i_acc[2*WIDTH-1:WIDTH];
  assign w_prod = w_neg ? -i_acc : i_acc;

  always_comb begin
    o_lo = '0;
    o_hi = '0;
    if (i_dz) begin
      // Accumulator low half still holds |dividend|; rebuild the original value.
      o_lo = '1;
      o_hi = i_sign_a ? -w_q : w_q;
    end else if (i_op == MD_OP_MUL) begin
      o_lo = w_prod[WIDTH-1:0];
      o_hi = w_prod[2*WIDTH-1:WIDTH];
    end else begin
      o_lo = w_neg    ? -w_q : w_q;
      o_hi = i_sign_a ? -w_r : w_r;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative signed multiply/divide for the EX stage: one shift-add or
// restoring-subtract step per cycle, sign fix-up in a final cycle.
module ex_muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = MD_ITERATIONS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             flush,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e          r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_dz;
  logic [WIDTH-1:0]   r_mag;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic               r_done;
  logic               r_busy;
  logic               r_dz_flag;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_trial;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_hi;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_is_dz;

  muldiv_sign_adjust #(.WIDTH(WIDTH)) u_sign (
    .i_a      (operand_a),
    .i_b      (operand_b),
    .i_op     (r_op),
    .i_dz     (r_dz),
    .i_sign_a (r_sign_a),
    .i_sign_b (r_sign_b),
    .i_acc    (r_acc),
    .o_mag_a  (w_mag_a),
    .o_mag_b  (w_mag_b),
    .o_lo     (w_lo),
    .o_hi     (w_hi)
  );

  // MUL: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  // DIV: acc = {remainder, dividend}; shift left, subtract divisor if it fits.
  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag} : '0);
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_trial - {1'b0, r_mag};
  assign w_div_ge    = (w_div_trial >= {1'b0, r_mag});
  assign w_div_hi    = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_trial[WIDTH-1:0];

  always_comb begin
    if (r_op == MD_OP_MUL)
      w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    else
      w_acc_next = {w_div_hi, r_acc[WIDTH-2:0], w_div_ge};
  end

  assign w_is_dz = (op == MD_OP_DIV) && (operand_b == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_op      <= MD_OP_MUL;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_dz      <= 1'b0;
      r_mag     <= '0;
      r_acc     <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_dz_flag <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !flush) begin
            r_op     <= op;
            r_sign_a <= operand_a[WIDTH-1];
            r_sign_b <= operand_b[WIDTH-1];
            r_mag    <= (op == MD_OP_DIV) ? w_mag_b : w_mag_a;
            r_acc    <= {{WIDTH{1'b0}}, (op == MD_OP_DIV) ? w_mag_a : w_mag_b};
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_dz     <= w_is_dz;
            r_state  <= w_is_dz ? FIX : ITER;
          end
        end
        ITER: begin
          if (flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) r_state <= FIX;
          end
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (!flush) begin
            r_lo      <= w_lo;
            r_hi      <= w_hi;
            r_dz_flag <= r_dz;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign result_lo   = r_lo;
  assign result_hi   = r_hi;
  assign done        = r_done;
  assign busy        = r_busy;
  assign div_by_zero = r_dz_flag;
  assign stall       = r_busy | (start & (r_state == IDLE) & ~flush);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed vector table, randomized ops against a
// plain-arithmetic model, and control sequences (re-start, flush, reset).
module tb_ex_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] operand_a = '0;
  logic [15:0] operand_b = '0;
  logic [15:0] result_lo, result_hi;
  logic        done, busy, div_by_zero, stall;

  int total = 0;
  int bad   = 0;

  ex_muldiv_unit #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .flush(flush),
    .operand_a(operand_a), .operand_b(operand_b),
    .result_lo(result_lo), .result_hi(result_hi),
    .done(done), .busy(busy), .div_by_zero(div_by_zero), .stall(stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic void model(input logic o, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] lo, output logic [15:0] hi, output logic dz);
    int sa, sb, p, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = 1'b0;
    if (o == 1'b0) begin
      p  = sa * sb;
      lo = p[15:0];
      hi = p[31:16];
    end else if (sb == 0) begin
      lo = 16'hFFFF;
      hi = a;
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[15:0];
      hi = r[15:0];
    end
  endfunction

  task automatic run_op(input string name, input logic o, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] lo, output logic [15:0] hi, output logic dz);
    int  n;
    int  lat;
    bit  stall_ok;
    lat = (o && b == 16'h0) ? 2 : 18;
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    #1 chk({name, ":stall_req"}, {31'd0, stall}, 32'd1);
    @(posedge clock); #1;
    start = 1'b0;
    n = 1;
    stall_ok = 1'b1;
    while (!done && n < 40) begin
      if (!stall) stall_ok = 1'b0;
      @(posedge clock); #1;
      n++;
    end
    chk({name, ":latency"}, n, lat);
    chk({name, ":stall_busy"}, {31'd0, stall_ok}, 32'd1);
    chk({name, ":stall_done"}, {30'd0, stall, busy}, 32'd0);
    lo = result_lo; hi = result_hi; dz = div_by_zero;
  endtask

  vec_t vecs[8];

  initial begin
    logic [15:0] lo, hi, elo, ehi;
    logic        dz, edz;
    int          dones, first_done;

    vecs[0] = '{1'b0, 16'h0003, 16'hFFFB, 16'hFFF1, 16'hFFFF, 1'b0};
    vecs[1] = '{1'b0, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF, 1'b0};
    vecs[2] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0};
    vecs[3] = '{1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0};
    vecs[4] = '{1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0};
    vecs[5] = '{1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
    vecs[6] = '{1'b1, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
    vecs[7] = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};

    repeat (2) @(posedge clock);
    #1;
    chk("reset_outs", {result_lo, result_hi}, 32'd0);
    chk("reset_flags", {28'd0, done, busy, div_by_zero, stall}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, lo, hi, dz);
      chk($sformatf("vec%0d:res", i), {lo, hi}, {vecs[i].lo, vecs[i].hi});
      chk($sformatf("vec%0d:dz", i), {31'd0, dz}, {31'd0, vecs[i].dz});
    end

    for (int i = 0; i < 30; i++) begin
      logic        o;
      logic [15:0] a, b;
      o = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 7 == 3) b = 16'h0000;
      if (i % 9 == 5) begin a = 16'h8000; b = 16'hFFFF; end
      model(o, a, b, elo, ehi, edz);
      run_op($sformatf("rnd%0d", i), o, a, b, lo, hi, dz);
      chk($sformatf("rnd%0d:res op=%0d a=%h b=%h", i, o, a, b), {lo, hi}, {elo, ehi});
      chk($sformatf("rnd%0d:dz", i), {31'd0, dz}, {31'd0, edz});
    end

    // Second start pulse at E5 must be ignored.
    @(negedge clock);
    start = 1'b1; op = 1'b0; operand_a = 16'd2; operand_b = 16'd3;
    dones = 0; first_done = -1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock); #1;
      start = (e == 4);
      if (e == 4) begin op = 1'b1; operand_a = 16'd100; operand_b = 16'd0; end
      if (done) begin
        dones++;
        if (first_done < 0) first_done = e + 1;
      end
    end
    chk("restart:dones", dones, 1);
    chk("restart:latency", first_done, 18);
    chk("restart:res", {result_lo, result_hi, 15'd0, div_by_zero}, {16'd6, 16'd0, 16'd0});

    // Flush sampled at E9: no done, results retained.
    @(negedge clock);
    start = 1'b1; op = 1'b0; operand_a = 16'h0100; operand_b = 16'h0100;
    dones = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock); #1;
      start = 1'b0;
      flush = (e == 8);
      if (e == 9) chk("flush:busy", {31'd0, busy}, 32'd0);
      if (done) dones++;
    end
    chk("flush:dones", dones, 0);
    chk("flush:res", {result_lo, result_hi}, {16'd6, 16'd0});

    // Flush and start together in IDLE: nothing starts.
    @(negedge clock);
    start = 1'b1; flush = 1'b1;
    #1 chk("flush_start:stall", {31'd0, stall}, 32'd0);
    @(posedge clock); #1;
    chk("flush_start:busy", {31'd0, busy}, 32'd0);
    start = 1'b0; flush = 1'b0;

    // Reset sampled at E10 of a DIV clears everything.
    run_op("pre_rst", 1'b1, 16'h4321, 16'h0000, lo, hi, dz);
    chk("pre_rst:res", {lo, hi, 15'd0, dz}, {16'hFFFF, 16'h4321, 16'd1});
    @(negedge clock);
    start = 1'b1; op = 1'b1; operand_a = 16'h1234; operand_b = 16'h0005;
    dones = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock); #1;
      start = 1'b0;
      reset = (e == 9);
      if (e == 10) begin
        chk("rst:outs", {result_lo, result_hi}, 32'd0);
        chk("rst:flags", {28'd0, done, busy, div_by_zero, stall}, 32'd0);
      end
      if (done) dones++;
    end
    chk("rst:dones", dones, 0);

    run_op("post_rst", 1'b1, 16'h0064, 16'h0007, lo, hi, dz);
    chk("post_rst:res", {lo, hi}, {16'h000E, 16'h0002});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
